// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The slave side is the loader itself; the master side feeds bytes and watches writes.
interface imem_loader_if;
   logic        Start;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        WrEn;
   logic [31:0] WrAddress;
   logic [31:0] WrWord;
   logic        CpuReset;
   logic        Busy;
   logic        Done;
   logic        Error;

   modport master (
      output Start, ByteIn, ByteValid,
      input  ByteReady, WrEn, WrAddress, WrWord, CpuReset, Busy, Done, Error
   );

   modport slave (
      input  Start, ByteIn, ByteValid,
      output ByteReady, WrEn, WrAddress, WrWord, CpuReset, Busy, Done, Error
   );
endinterface

// File: rtl/imem_loader.sv
// Loads a program image (16-bit word count, then MSB-first words) from a byte stream
// into instruction memory, holding the CPU in reset until the image is complete.
module imem_loader #(
   parameter int          MEM_WORDS = 64,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_HI,
      HDR_LO,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

   state_t      stateQ, stateD;
   logic [15:0] countQ, countD;
   logic [15:0] wordCntQ, wordCntD;
   logic [1:0]  byteIdxQ, byteIdxD;
   logic [23:0] shiftQ, shiftD;
   logic [31:0] wrAddrQ, wrAddrD;
   logic [31:0] wrWordQ, wrWordD;
   logic        readyQ, readyD;
   logic        wrEnQ, wrEnD;
   logic        cpuRstQ, cpuRstD;
   logic        busyQ, busyD;
   logic        doneQ, doneD;
   logic        errQ, errD;

   logic        accept;
   logic [15:0] hdrCount;
   logic [15:0] nextWordCnt;

   assign accept      = bus.ByteValid & readyQ;
   assign hdrCount    = {countQ[15:8], bus.ByteIn};
   assign nextWordCnt = wordCntQ + 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ   <= IDLE;
         countQ   <= '0;
         wordCntQ <= '0;
         byteIdxQ <= '0;
         shiftQ   <= '0;
         wrAddrQ  <= BASE_ADDR;
         wrWordQ  <= '0;
         readyQ   <= 1'b0;
         wrEnQ    <= 1'b0;
         cpuRstQ  <= 1'b0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
         errQ     <= 1'b0;
      end else begin
         stateQ   <= stateD;
         countQ   <= countD;
         wordCntQ <= wordCntD;
         byteIdxQ <= byteIdxD;
         shiftQ   <= shiftD;
         wrAddrQ  <= wrAddrD;
         wrWordQ  <= wrWordD;
         readyQ   <= readyD;
         wrEnQ    <= wrEnD;
         cpuRstQ  <= cpuRstD;
         busyQ    <= busyD;
         doneQ    <= doneD;
         errQ     <= errD;
      end
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_comb begin
      stateD   = stateQ;
      countD   = countQ;
      wordCntD = wordCntQ;
      byteIdxD = byteIdxQ;
      shiftD   = shiftQ;
      wrAddrD  = wrAddrQ;
      wrWordD  = wrWordQ;
      cpuRstD  = cpuRstQ;
      doneD    = doneQ;
      errD     = errQ;

      case (stateQ)
         IDLE, DONE, ERR: begin
            if (bus.Start) begin
               stateD   = HDR_HI;
               doneD    = 1'b0;
               errD     = 1'b0;
               cpuRstD  = 1'b1;
               wordCntD = '0;
            end
         end
         HDR_HI: begin
            if (accept) begin
               countD = {bus.ByteIn, countQ[7:0]};
               stateD = HDR_LO;
            end
         end
         HDR_LO: begin
            if (accept) begin
               countD   = hdrCount;
               byteIdxD = '0;
               if (hdrCount == 16'd0) begin
                  stateD  = DONE;
                  doneD   = 1'b1;
                  cpuRstD = 1'b0;
               end else if (hdrCount > 16'(MEM_WORDS)) begin
                  stateD = ERR;
                  errD   = 1'b1;
               end else begin
                  stateD = DATA;
               end
            end
         end
         DATA: begin
            if (accept) begin
               shiftD   = {shiftQ[15:0], bus.ByteIn};
               byteIdxD = byteIdxQ + 2'd1;
               if (byteIdxQ == 2'd3) begin
                  stateD  = WRITE;
                  wrWordD = {shiftQ, bus.ByteIn};
                  wrAddrD = BASE_ADDR + {14'd0, wordCntQ, 2'b00};
               end
            end
         end
         WRITE: begin
            wordCntD = nextWordCnt;
            if (nextWordCnt == countQ) begin
               stateD  = DONE;
               doneD   = 1'b1;
               cpuRstD = 1'b0;
            end else begin
               stateD = DATA;
            end
         end
         default: stateD = IDLE;
      endcase

      readyD = (stateD == HDR_HI) || (stateD == HDR_LO) || (stateD == DATA);
      wrEnD  = (stateD == WRITE);
      busyD  = readyD || (stateD == WRITE);
   end

   assign bus.ByteReady = readyQ;
   assign bus.WrEn      = wrEnQ;
   assign bus.WrAddress = wrAddrQ;
   assign bus.WrWord    = wrWordQ;
   assign bus.CpuReset  = cpuRstQ;
   assign bus.Busy      = busyQ;
   assign bus.Done      = doneQ;
   assign bus.Error     = errQ;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: the expected write list is derived from the image
// bytes sent, and a monitor compares every WrEn cycle against it.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   imem_loader_if bus ();

   imem_loader #(
      .MEM_WORDS(64),
      .BASE_ADDR(BASE)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int          tests = 0;
   int          fails = 0;
   int          expIdx = 0;
   int          writeCount = 0;
   int          writesBefore;
   logic [31:0] lastAddr = '0;
   logic [31:0] expAddrQ[$];
   logic [31:0] expWordQ[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Every write strobe must match the next word the image dictates, with the stream stalled.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.WrEn === 1'b1) begin
         writeCount++;
         lastAddr = bus.WrAddress;
         checkOutput("ready_in_write", {31'd0, bus.ByteReady}, 32'd0);
         if (expAddrQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_write: got addr %h word %h required no write",
                     bus.WrAddress, bus.WrWord);
         end else begin
            checkOutput("wr_addr", bus.WrAddress, expAddrQ.pop_front());
            checkOutput("wr_word", bus.WrWord, expWordQ.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int waitCnt = 0;
      bus.ByteIn    = b;
      bus.ByteValid = 1'b1;
      while (bus.ByteReady !== 1'b1 && waitCnt < 20) begin
         @(negedge clk);
         waitCnt++;
      end
      if (waitCnt >= 20) begin
         tests++;
         fails++;
         $display("[TB] FAIL byte_timeout: byte %h never accepted, ByteReady %b required 1",
                  b, bus.ByteReady);
         bus.ByteValid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.ByteValid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulseStart(input bit expectTaken);
      bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      if (expectTaken) expIdx = 0;
   endtask

   task automatic sendWord(input logic [31:0] w, input int gap);
      expAddrQ.push_back(BASE + 32'(4 * expIdx));
      expWordQ.push_back(w);
      expIdx++;
      applyStimulus(w[31:24], gap);
      applyStimulus(w[23:16], gap);
      applyStimulus(w[15:8], gap);
      applyStimulus(w[7:0], gap);
   endtask

   task automatic waitDone(input string name);
      int n = 0;
      while (bus.Done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'd0, bus.Done}, 32'd1);
      checkOutput({name, "_cpureset"}, {31'd0, bus.CpuReset}, 32'd0);
      checkOutput({name, "_ready"}, {31'd0, bus.ByteReady}, 32'd0);
      checkOutput({name, "_busy"}, {31'd0, bus.Busy}, 32'd0);
      checkOutput({name, "_pending"}, 32'(expAddrQ.size()), 32'd0);
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, "_ready"}, {31'd0, bus.ByteReady}, 32'd0);
      checkOutput({name, "_wren"}, {31'd0, bus.WrEn}, 32'd0);
      checkOutput({name, "_addr"}, bus.WrAddress, BASE);
      checkOutput({name, "_word"}, bus.WrWord, 32'd0);
      checkOutput({name, "_cpureset"}, {31'd0, bus.CpuReset}, 32'd0);
      checkOutput({name, "_busy"}, {31'd0, bus.Busy}, 32'd0);
      checkOutput({name, "_done"}, {31'd0, bus.Done}, 32'd0);
      checkOutput({name, "_error"}, {31'd0, bus.Error}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset         = 1'b1;
      bus.Start     = 1'b0;
      bus.ByteIn    = 8'h00;
      bus.ByteValid = 1'b0;
      repeat (2) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] two-word image, ByteValid held");
      pulseStart(1'b1);
      checkOutput("start_cpureset", {31'd0, bus.CpuReset}, 32'd1);
      checkOutput("start_busy", {31'd0, bus.Busy}, 32'd1);
      checkOutput("start_ready", {31'd0, bus.ByteReady}, 32'd1);
      expAddrQ.push_back(32'h0000_0000); expWordQ.push_back(32'h2400_0120);
      expAddrQ.push_back(32'h0000_0004); expWordQ.push_back(32'h0800_0080);
      writesBefore = writeCount;
      applyStimulus(8'h00, 0); applyStimulus(8'h02, 0);
      applyStimulus(8'h24, 0); applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0); applyStimulus(8'h20, 0);
      applyStimulus(8'h08, 0); applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0); applyStimulus(8'h80, 0);
      checkOutput("last_write_strobe", {31'd0, bus.WrEn}, 32'd1);
      checkOutput("cpureset_during_last_write", {31'd0, bus.CpuReset}, 32'd1);
      @(negedge clk);
      checkOutput("cpureset_after_last_write", {31'd0, bus.CpuReset}, 32'd0);
      waitDone("two_word_done");
      checkOutput("two_word_count", 32'(writeCount - writesBefore), 32'd2);

      $display("[TB] empty image");
      writesBefore = writeCount;
      pulseStart(1'b1);
      checkOutput("empty_done_cleared", {31'd0, bus.Done}, 32'd0);
      applyStimulus(8'h00, 0); applyStimulus(8'h00, 0);
      @(negedge clk);
      checkOutput("empty_done", {31'd0, bus.Done}, 32'd1);
      checkOutput("empty_cpureset", {31'd0, bus.CpuReset}, 32'd0);
      checkOutput("empty_count", 32'(writeCount - writesBefore), 32'd0);

      $display("[TB] oversize image then recovery");
      writesBefore = writeCount;
      pulseStart(1'b1);
      applyStimulus(8'h00, 0); applyStimulus(8'h41, 0);
      @(negedge clk);
      checkOutput("oversize_error", {31'd0, bus.Error}, 32'd1);
      checkOutput("oversize_cpureset", {31'd0, bus.CpuReset}, 32'd1);
      checkOutput("oversize_busy", {31'd0, bus.Busy}, 32'd0);
      checkOutput("oversize_ready", {31'd0, bus.ByteReady}, 32'd0);
      checkOutput("oversize_done", {31'd0, bus.Done}, 32'd0);
      checkOutput("oversize_count", 32'(writeCount - writesBefore), 32'd0);
      pulseStart(1'b1);
      checkOutput("recover_error_cleared", {31'd0, bus.Error}, 32'd0);
      applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
      sendWord(32'hDEAD_BEEF, 0);
      waitDone("recover_done");
      checkOutput("recover_error", {31'd0, bus.Error}, 32'd0);

      $display("[TB] one-word image, ByteValid toggling");
      writesBefore = writeCount;
      pulseStart(1'b1);
      applyStimulus(8'h00, 1); applyStimulus(8'h01, 1);
      sendWord(32'h1357_9BDF, 1);
      waitDone("toggle_done");
      checkOutput("toggle_count", 32'(writeCount - writesBefore), 32'd1);

      $display("[TB] Start during DATA ignored");
      pulseStart(1'b1);
      applyStimulus(8'h00, 0); applyStimulus(8'h02, 0);
      sendWord(32'h1122_3344, 0);
      @(negedge clk);
      pulseStart(1'b0);
      sendWord(32'h5566_7788, 0);
      waitDone("midstart_done");

      $display("[TB] reset in the middle of a word");
      writesBefore = writeCount;
      pulseStart(1'b1);
      applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
      applyStimulus(8'hAA, 0); applyStimulus(8'hBB, 0);
      reset = 1'b1;
      #1;
      checkResetValues("midreset");
      @(negedge clk);
      reset         = 1'b0;
      bus.ByteIn    = 8'hCC;
      bus.ByteValid = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("midreset_idle_ready", {31'd0, bus.ByteReady}, 32'd0);
      checkOutput("midreset_idle_busy", {31'd0, bus.Busy}, 32'd0);
      checkOutput("midreset_count", 32'(writeCount - writesBefore), 32'd0);
      bus.ByteValid = 1'b0;

      $display("[TB] full 64-word image");
      writesBefore = writeCount;
      pulseStart(1'b1);
      applyStimulus(8'h00, 0); applyStimulus(8'h40, 0);
      for (int i = 0; i < 64; i++) begin
         sendWord(32'h0001_0203 + 32'(i) * 32'h0404_0404, 0);
      end
      waitDone("full_done");
      checkOutput("full_last_addr", lastAddr, 32'h0000_00FC);
      checkOutput("full_count", 32'(writeCount - writesBefore), 32'd64);
      bus.ByteIn    = 8'hEE;
      bus.ByteValid = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("extra_byte_ready", {31'd0, bus.ByteReady}, 32'd0);
      checkOutput("extra_byte_done", {31'd0, bus.Done}, 32'd1);
      checkOutput("extra_byte_count", 32'(writeCount - writesBefore), 32'd64);
      bus.ByteValid = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
